// File: rtl/lsu_seq_if.sv
// Bus bundle between the load/store unit and its neighbours (decode, register file, data memory).
// The master modport is the LSU side; the slave modport is the surrounding pipeline and memory.
interface lsu_seq_if #(
    parameter int DW = 32,
    parameter int AW = 22,
    parameter int RW = 5
);
    logic          start;
    logic [4:0]    opcode;
    logic [RW-1:0] rdst;
    logic [AW-1:0] address;
    logic          busy;
    logic          done;
    logic          err;
    logic          rf_re;
    logic [RW-1:0] rf_raddr;
    logic [DW-1:0] rf_rdata;
    logic          rf_we;
    logic [RW-1:0] rf_waddr;
    logic [DW-1:0] rf_wdata;
    logic          mem_req;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          mem_ack;

    modport master (
        input  start, opcode, rdst, address, rf_rdata, mem_rdata, mem_ack,
        output busy, done, err, rf_re, rf_raddr, rf_we, rf_waddr, rf_wdata,
               mem_req, mem_we, mem_addr, mem_wdata
    );

    modport slave (
        output start, opcode, rdst, address, rf_rdata, mem_rdata, mem_ack,
        input  busy, done, err, rf_re, rf_raddr, rf_we, rf_waddr, rf_wdata,
               mem_req, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/lsu_seq.sv
// Sequential load/store unit: one load, store or no-op per start, req/ack memory access, one-cycle done.
// Optional memory-ack timeout with abort flag is enabled by defining LSU_TIMEOUT_EN.
module lsu_seq #(
    parameter int DW          = 32,
    parameter int AW          = 22,
    parameter int RW          = 5,
    parameter int MEM_TIMEOUT = 16
) (
    input  logic      clk,
    input  logic      rst_n,
    lsu_seq_if.master bus
);
    typedef enum logic [2:0] {
        IDLE,
        RF_RD,
        RF_CAP,
        MEM_REQ,
        WB,
        FIN
    } state_e;

    state_e        state_q;
    logic          isStore_q;
    logic [RW-1:0] rdst_q;
    logic [AW-1:0] addr_q;
    logic [DW-1:0] data_q;
    logic          busy_q;
    logic          done_q;
    logic          rfRe_q;
    logic          rfWe_q;
    logic          memReq_q;

`ifdef LSU_TIMEOUT_EN
    localparam int CW = $clog2(MEM_TIMEOUT + 1);
    logic [CW-1:0] count_q;
    logic          err_q;
    logic          limitHit;

    // The limit is reached in the MEM_TIMEOUT-th request cycle, i.e. when count_q holds MEM_TIMEOUT-1.
    assign limitHit = (count_q == CW'(MEM_TIMEOUT - 1));
    assign bus.err  = err_q;
`else
    logic unusedTimeout;
    assign unusedTimeout = (MEM_TIMEOUT >= 1);
    assign bus.err       = 1'b0;
`endif

    // data_q doubles as the store operand and the captured load data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            isStore_q <= 1'b0;
            rdst_q    <= '0;
            addr_q    <= '0;
            data_q    <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            rfRe_q    <= 1'b0;
            rfWe_q    <= 1'b0;
            memReq_q  <= 1'b0;
`ifdef LSU_TIMEOUT_EN
            count_q   <= '0;
            err_q     <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            rfRe_q <= 1'b0;
            rfWe_q <= 1'b0;
`ifdef LSU_TIMEOUT_EN
            err_q  <= 1'b0;
`endif
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        isStore_q <= bus.opcode[3];
                        rdst_q    <= bus.rdst;
                        addr_q    <= bus.address;
                        busy_q    <= 1'b1;
                        if (!bus.opcode[4]) begin
                            state_q <= FIN;
                            done_q  <= 1'b1;
                        end else if (bus.opcode[3]) begin
                            state_q <= RF_RD;
                            rfRe_q  <= 1'b1;
                        end else begin
                            state_q  <= MEM_REQ;
                            memReq_q <= 1'b1;
`ifdef LSU_TIMEOUT_EN
                            count_q  <= '0;
`endif
                        end
                    end
                end
                RF_RD: begin
                    state_q <= RF_CAP;
                end
                RF_CAP: begin
                    data_q   <= bus.rf_rdata;
                    state_q  <= MEM_REQ;
                    memReq_q <= 1'b1;
`ifdef LSU_TIMEOUT_EN
                    count_q  <= '0;
`endif
                end
                MEM_REQ: begin
                    // An ack in the same cycle as the timeout limit takes priority over the abort.
                    if (bus.mem_ack) begin
                        memReq_q <= 1'b0;
                        if (isStore_q) begin
                            state_q <= FIN;
                            done_q  <= 1'b1;
                        end else begin
                            data_q  <= bus.mem_rdata;
                            state_q <= WB;
                            rfWe_q  <= 1'b1;
                        end
`ifdef LSU_TIMEOUT_EN
                    end else if (limitHit) begin
                        memReq_q <= 1'b0;
                        state_q  <= FIN;
                        done_q   <= 1'b1;
                        err_q    <= 1'b1;
                    end else begin
                        count_q <= count_q + 1'b1;
`endif
                    end
                end
                WB: begin
                    state_q <= FIN;
                    done_q  <= 1'b1;
                end
                FIN: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q  <= IDLE;
                    busy_q   <= 1'b0;
                    memReq_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.rf_re     = rfRe_q;
    assign bus.rf_raddr  = rdst_q;
    assign bus.rf_we     = rfWe_q;
    assign bus.rf_waddr  = rdst_q;
    assign bus.rf_wdata  = data_q;
    assign bus.mem_req   = memReq_q;
    assign bus.mem_we    = isStore_q;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = data_q;
endmodule

// File: tb/tb_lsu_seq.sv
// Randomised bench for lsu_seq: per-cycle trace of each transaction is compared against a latency model.
// Builds with or without LSU_TIMEOUT_EN; the DUT is given MEM_TIMEOUT=4.
module tb_lsu_seq;
    localparam int DW   = 32;
    localparam int AW   = 22;
    localparam int RW   = 5;
    localparam int TMO  = 4;
    localparam int NCYC = 28;
`ifdef LSU_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   checks   = 0;
    int   failures = 0;

    lsu_seq_if #(.DW(DW), .AW(AW), .RW(RW)) bus ();

    lsu_seq #(.DW(DW), .AW(AW), .RW(RW), .MEM_TIMEOUT(TMO)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          busy, done, err, rf_re, rf_we, mem_req, mem_we;
        logic [RW-1:0] rf_raddr, rf_waddr;
        logic [DW-1:0] rf_wdata, mem_wdata;
        logic [AW-1:0] mem_addr;
    } obs_t;

    typedef struct packed {
        logic busy, done, err, rf_re, rf_we, mem_req;
    } exp_t;

    typedef struct {
        logic [4:0]    op;
        int            w;
        bit            noise;
        logic [RW-1:0] rd;
        logic [AW-1:0] addr;
        logic [DW-1:0] rfd;
        logic [DW-1:0] memd;
    } txn_t;

    obs_t tr[NCYC];

    // Expected strobes at cycle T0+k: kind 0=no-op, 1=load, 2=store; w = wait cycles before ack (-1 = never).
    function automatic exp_t model(input int kind, input int w, input int k);
        exp_t e;
        int   req0;
        int   last;
        int   fin;
        bit   abort;
        e = '0;
        if (kind == 0) begin
            fin = 1;
        end else begin
            req0  = (kind == 2) ? 3 : 1;
            abort = TO_EN && (w < 0 || w >= TMO);
            last  = abort ? req0 + TMO - 1 : req0 + w;
            fin   = (abort || kind == 2) ? last + 1 : last + 2;
            e.mem_req = (k >= req0) && (k <= last);
            e.rf_we   = !abort && (kind == 1) && (k == last + 1);
            e.rf_re   = (kind == 2) && (k == 1);
            e.err     = abort && (k == fin);
        end
        e.busy = (k >= 1) && (k <= fin);
        e.done = (k == fin);
        return e;
    endfunction

    // Drives one start at k=0, acts as register file and memory, and records outputs each cycle.
    task automatic run_txn(input txn_t c);
        int reqSeen = 0;
        for (int k = 0; k < NCYC; k++) begin
            @(negedge clk);
            tr[k].busy      = bus.busy;
            tr[k].done      = bus.done;
            tr[k].err       = bus.err;
            tr[k].rf_re     = bus.rf_re;
            tr[k].rf_we     = bus.rf_we;
            tr[k].mem_req   = bus.mem_req;
            tr[k].mem_we    = bus.mem_we;
            tr[k].rf_raddr  = bus.rf_raddr;
            tr[k].rf_waddr  = bus.rf_waddr;
            tr[k].rf_wdata  = bus.rf_wdata;
            tr[k].mem_wdata = bus.mem_wdata;
            tr[k].mem_addr  = bus.mem_addr;
            bus.start = (k == 0) || (c.noise && tr[k].busy);
            if (k == 0) begin
                bus.opcode  = c.op;
                bus.rdst    = c.rd;
                bus.address = c.addr;
            end else if (c.noise) begin
                bus.opcode  = 5'($urandom);
                bus.rdst    = RW'($urandom);
                bus.address = AW'($urandom);
            end
            if (tr[k].mem_req)
                bus.mem_ack = (reqSeen == c.w);
            else
                bus.mem_ack = c.noise ? 1'($urandom_range(0, 1)) : 1'b0;
            bus.mem_rdata = (tr[k].mem_req && bus.mem_ack) ? c.memd : $urandom;
            bus.rf_rdata  = (k > 0 && tr[k-1].rf_re) ? c.rfd : $urandom;
            if (tr[k].mem_req)
                reqSeen++;
        end
        bus.start   = 1'b0;
        bus.mem_ack = 1'b0;
    endtask

    task automatic test_reset();
        bus.start     = 1'b0;
        bus.opcode    = '0;
        bus.rdst      = '0;
        bus.address   = '0;
        bus.rf_rdata  = '0;
        bus.mem_rdata = '0;
        bus.mem_ack   = 1'b0;
        rst_n         = 1'b0;
        repeat (3) @(negedge clk);
        checks += 12;
        if (bus.busy !== 1'b0)     begin failures++; $display("[TB] FAIL reset_busy got=%b exp=0", bus.busy); end
        if (bus.done !== 1'b0)     begin failures++; $display("[TB] FAIL reset_done got=%b exp=0", bus.done); end
        if (bus.err !== 1'b0)      begin failures++; $display("[TB] FAIL reset_err got=%b exp=0", bus.err); end
        if (bus.rf_re !== 1'b0)    begin failures++; $display("[TB] FAIL reset_rf_re got=%b exp=0", bus.rf_re); end
        if (bus.rf_we !== 1'b0)    begin failures++; $display("[TB] FAIL reset_rf_we got=%b exp=0", bus.rf_we); end
        if (bus.mem_req !== 1'b0)  begin failures++; $display("[TB] FAIL reset_mem_req got=%b exp=0", bus.mem_req); end
        if (bus.mem_we !== 1'b0)   begin failures++; $display("[TB] FAIL reset_mem_we got=%b exp=0", bus.mem_we); end
        if (bus.mem_addr !== '0)   begin failures++; $display("[TB] FAIL reset_mem_addr got=%h exp=0", bus.mem_addr); end
        if (bus.mem_wdata !== '0)  begin failures++; $display("[TB] FAIL reset_mem_wdata got=%h exp=0", bus.mem_wdata); end
        if (bus.rf_wdata !== '0)   begin failures++; $display("[TB] FAIL reset_rf_wdata got=%h exp=0", bus.rf_wdata); end
        if (bus.rf_waddr !== '0)   begin failures++; $display("[TB] FAIL reset_rf_waddr got=%h exp=0", bus.rf_waddr); end
        if (bus.rf_raddr !== '0)   begin failures++; $display("[TB] FAIL reset_rf_raddr got=%h exp=0", bus.rf_raddr); end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_transactions();
        txn_t q[$];
        txn_t c;
        int   kind;
        exp_t e;
        q.push_back('{op: 5'b10000, w: 0, noise: 1'b0, rd: 5'd7, addr: 22'h00ABC, rfd: 32'h0, memd: 32'hDEADBEEF});
        q.push_back('{op: 5'b11000, w: 3, noise: 1'b0, rd: 5'd3, addr: 22'h3F00D, rfd: 32'h12345678, memd: 32'h0});
        q.push_back('{op: 5'b00101, w: 0, noise: 1'b0, rd: 5'd9, addr: 22'h12345, rfd: 32'h0, memd: 32'h0});
        q.push_back('{op: 5'b10000, w: 2, noise: 1'b1, rd: 5'd21, addr: 22'h2AAAA, rfd: 32'h0, memd: 32'hCAFEF00D});
        q.push_back('{op: 5'b11111, w: 0, noise: 1'b1, rd: 5'd31, addr: 22'h3FFFF, rfd: 32'hFFFFFFFF, memd: 32'h0});
        q.push_back('{op: 5'b10000, w: 3, noise: 1'b0, rd: 5'd1, addr: 22'h00001, rfd: 32'h0, memd: 32'h80000001});
`ifdef LSU_TIMEOUT_EN
        q.push_back('{op: 5'b10000, w: -1, noise: 1'b0, rd: 5'd5, addr: 22'h01234, rfd: 32'h0, memd: 32'h55AA55AA});
        q.push_back('{op: 5'b11000, w: -1, noise: 1'b1, rd: 5'd6, addr: 22'h04321, rfd: 32'hA5A5A5A5, memd: 32'h0});
`else
        q.push_back('{op: 5'b10000, w: 20, noise: 1'b0, rd: 5'd5, addr: 22'h01234, rfd: 32'h0, memd: 32'h55AA55AA});
`endif
        for (int i = 0; i < 30; i++) begin
            kind     = $urandom_range(0, 2);
            c.op     = 5'($urandom);
            c.op[4]  = (kind != 0);
            if (kind != 0)
                c.op[3] = (kind == 2);
            c.w      = $urandom_range(0, 6);
            c.noise  = 1'($urandom_range(0, 1));
            c.rd     = RW'($urandom);
            c.addr   = AW'($urandom);
            c.rfd    = $urandom;
            c.memd   = $urandom;
            q.push_back(c);
        end
        foreach (q[i]) begin
            c    = q[i];
            kind = !c.op[4] ? 0 : (c.op[3] ? 2 : 1);
            run_txn(c);
            for (int k = 0; k < NCYC; k++) begin
                e = model(kind, c.w, k);
                checks += 6;
                if (tr[k].busy !== e.busy)       begin failures++; $display("[TB] FAIL busy txn=%0d k=%0d got=%b exp=%b", i, k, tr[k].busy, e.busy); end
                if (tr[k].done !== e.done)       begin failures++; $display("[TB] FAIL done txn=%0d k=%0d got=%b exp=%b", i, k, tr[k].done, e.done); end
                if (tr[k].err !== e.err)         begin failures++; $display("[TB] FAIL err txn=%0d k=%0d got=%b exp=%b", i, k, tr[k].err, e.err); end
                if (tr[k].rf_re !== e.rf_re)     begin failures++; $display("[TB] FAIL rf_re txn=%0d k=%0d got=%b exp=%b", i, k, tr[k].rf_re, e.rf_re); end
                if (tr[k].rf_we !== e.rf_we)     begin failures++; $display("[TB] FAIL rf_we txn=%0d k=%0d got=%b exp=%b", i, k, tr[k].rf_we, e.rf_we); end
                if (tr[k].mem_req !== e.mem_req) begin failures++; $display("[TB] FAIL mem_req txn=%0d k=%0d got=%b exp=%b", i, k, tr[k].mem_req, e.mem_req); end
                if (e.rf_re) begin
                    checks++;
                    if (tr[k].rf_raddr !== c.rd) begin failures++; $display("[TB] FAIL rf_raddr txn=%0d k=%0d got=%h exp=%h", i, k, tr[k].rf_raddr, c.rd); end
                end
                if (e.rf_we) begin
                    checks += 2;
                    if (tr[k].rf_waddr !== c.rd)   begin failures++; $display("[TB] FAIL rf_waddr txn=%0d k=%0d got=%h exp=%h", i, k, tr[k].rf_waddr, c.rd); end
                    if (tr[k].rf_wdata !== c.memd) begin failures++; $display("[TB] FAIL rf_wdata txn=%0d k=%0d got=%h exp=%h", i, k, tr[k].rf_wdata, c.memd); end
                end
                if (e.mem_req) begin
                    checks += 2;
                    if (tr[k].mem_we !== (kind == 2)) begin failures++; $display("[TB] FAIL mem_we txn=%0d k=%0d got=%b exp=%b", i, k, tr[k].mem_we, kind == 2); end
                    if (tr[k].mem_addr !== c.addr)    begin failures++; $display("[TB] FAIL mem_addr txn=%0d k=%0d got=%h exp=%h", i, k, tr[k].mem_addr, c.addr); end
                    if (kind == 2) begin
                        checks++;
                        if (tr[k].mem_wdata !== c.rfd) begin failures++; $display("[TB] FAIL mem_wdata txn=%0d k=%0d got=%h exp=%h", i, k, tr[k].mem_wdata, c.rfd); end
                    end
                end
            end
        end
    endtask

    task automatic test_async_reset();
        txn_t c;
        @(negedge clk);
        bus.start   = 1'b1;
        bus.opcode  = 5'b10000;
        bus.rdst    = 5'd9;
        bus.address = 22'h155AA;
        bus.mem_ack = 1'b0;
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.mem_req !== 1'b1) begin failures++; $display("[TB] FAIL arst_pre_req got=%b exp=1", bus.mem_req); end
        #2 rst_n = 1'b0;
        #1;
        checks += 4;
        if (bus.mem_req !== 1'b0) begin failures++; $display("[TB] FAIL arst_mem_req got=%b exp=0", bus.mem_req); end
        if (bus.busy !== 1'b0)    begin failures++; $display("[TB] FAIL arst_busy got=%b exp=0", bus.busy); end
        if (bus.done !== 1'b0)    begin failures++; $display("[TB] FAIL arst_done got=%b exp=0", bus.done); end
        if (bus.rf_we !== 1'b0)   begin failures++; $display("[TB] FAIL arst_rf_we got=%b exp=0", bus.rf_we); end
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = 32'h0BADF00D;
        @(negedge clk);
        bus.mem_ack = 1'b0;
        rst_n       = 1'b1;
        repeat (2) begin
            @(negedge clk);
            checks += 2;
            if (bus.rf_we !== 1'b0) begin failures++; $display("[TB] FAIL arst_post_rf_we got=%b exp=0", bus.rf_we); end
            if (bus.busy !== 1'b0)  begin failures++; $display("[TB] FAIL arst_post_busy got=%b exp=0", bus.busy); end
        end
        c = '{op: 5'b10000, w: 1, noise: 1'b0, rd: 5'd12, addr: 22'h2C0DE, rfd: 32'h0, memd: 32'h600DCAFE};
        run_txn(c);
        checks += 4;
        if (tr[3].rf_we !== 1'b1)           begin failures++; $display("[TB] FAIL arst_reload_rf_we got=%b exp=1", tr[3].rf_we); end
        if (tr[3].rf_wdata !== 32'h600DCAFE) begin failures++; $display("[TB] FAIL arst_reload_wdata got=%h exp=600dcafe", tr[3].rf_wdata); end
        if (tr[4].done !== 1'b1)            begin failures++; $display("[TB] FAIL arst_reload_done got=%b exp=1", tr[4].done); end
        if (tr[2].mem_addr !== 22'h2C0DE)   begin failures++; $display("[TB] FAIL arst_reload_addr got=%h exp=2c0de", tr[2].mem_addr); end
    endtask

    initial begin
        test_reset();
        test_transactions();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
